// File: rtl/tlk2711_pkg.sv
// Shared FSM encoding, default widths and command-word field layout for the
// TLK2711 TX command arbiter.
package tlk2711_pkg;

  localparam int unsigned DEF_CH_NUM         = 4;
  localparam int unsigned DEF_ADDR_WIDTH     = 48;
  localparam int unsigned DEF_DLEN_WIDTH     = 16;
  localparam int unsigned DEF_BNUM_WIDTH     = 24;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

  // Command word is {length, address}: address at the LSBs.
  localparam int unsigned CMD_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARB       = 2'd1,
    REQ       = 2'd2,
    WAIT_LAST = 2'd3
  } arb_state_e;

  // Length field starts directly above the address field.
  function automatic int unsigned cmd_len_lsb(input int unsigned addr_width);
    return addr_width;
  endfunction

endpackage

// File: rtl/tlk2711_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted channel; the
// pointer moves only on adv so a grant is stable until it is consumed.
module tlk2711_rr_arb #(
  parameter int unsigned CH_NUM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [CH_NUM-1:0] req,
  input  logic              adv,
  output logic [CH_NUM-1:0] grant_c
);

  localparam int unsigned PW = $clog2(CH_NUM);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          hit;

  // First pass covers channels above the pointer, second pass wraps around.
  always_comb begin
    grant_c = '0;
    hit     = 1'b0;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (!hit && req[j] && (PW'(j) > ptr)) begin
        grant_c[j] = 1'b1;
        hit        = 1'b1;
      end
    end
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (!hit && req[j] && (PW'(j) <= ptr)) begin
        grant_c[j] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (grant_c[j]) ptr_nxt = PW'(j);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PW'(CH_NUM - 1);
    end else if (clr) begin
      ptr <= PW'(CH_NUM - 1);
    end else if (adv) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/tlk2711_tx_cmd_arb.sv
// TLK2711 TX DMA read-command arbiter: splits each channel job into body/tail
// commands and issues them one at a time, round-robin across channels.
// Optional WAIT_LAST watchdog (o_timeout port) when TLK2711_TX_CMD_TIMEOUT_EN is defined.
module tlk2711_tx_cmd_arb
  import tlk2711_pkg::*;
#(
  parameter int unsigned CH_NUM         = DEF_CH_NUM,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DLEN_WIDTH     = DEF_DLEN_WIDTH,
  parameter int unsigned BNUM_WIDTH     = DEF_BNUM_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_soft_rst,
  input  logic [CH_NUM-1:0]                i_tx_start,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     i_tx_base_addr,
  input  logic [CH_NUM*DLEN_WIDTH-1:0]     i_tx_packet_body,
  input  logic [CH_NUM*DLEN_WIDTH-1:0]     i_tx_packet_tail,
  input  logic [CH_NUM*BNUM_WIDTH-1:0]     i_tx_body_num,
  output logic                             o_rd_cmd_req,
  input  logic                             i_rd_cmd_ack,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
  output logic [$clog2(CH_NUM)-1:0]        o_rd_cmd_ch,
  input  logic                             i_dma_rd_last,
  output logic [CH_NUM-1:0]                o_ch_busy,
  output logic [CH_NUM-1:0]                o_ch_done
`ifdef TLK2711_TX_CMD_TIMEOUT_EN
  ,
  output logic                             o_timeout
`endif
);

  localparam int unsigned CH_W    = $clog2(CH_NUM);
  localparam int unsigned CMD_W   = DLEN_WIDTH + ADDR_WIDTH;
  localparam int unsigned LEN_LSB = cmd_len_lsb(ADDR_WIDTH);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e state;
  arb_state_e state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q     [CH_NUM];
  logic [DLEN_WIDTH-1:0] body_len_q [CH_NUM];
  logic [DLEN_WIDTH-1:0] tail_len_q [CH_NUM];
  logic [BNUM_WIDTH-1:0] body_rem_q [CH_NUM];
  logic [CH_NUM-1:0]     tail_pend_q;

  logic [CH_NUM-1:0] has_body;
  logic [CH_NUM-1:0] has_tail;
  logic [CH_NUM-1:0] start_acc;
  logic [CH_NUM-1:0] start_job;
  logic [CH_NUM-1:0] start_empty;
  logic [CH_NUM-1:0] grant_c;
  logic [CH_NUM-1:0] cur_onehot;
  logic [CH_NUM-1:0] clr_vec;
  logic [CH_NUM-1:0] busy_nxt;
  logic [CH_NUM-1:0] done_nxt;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   ch_nxt;
  logic [DLEN_WIDTH-1:0] cur_len;
  logic [DLEN_WIDTH-1:0] nxt_len;
  logic [BNUM_WIDTH-1:0] cur_rem;
  logic [CMD_W-1:0]  nxt_data;
  logic [CMD_W-1:0]  data_nxt;
  logic              req_nxt;
  logic              adv;
  logic              fin;
  logic              fin_last;
  logic              timeout_hit;

  // Decode start pulses; a job without any command completes immediately.
  always_comb begin
    has_body    = '0;
    has_tail    = '0;
    start_acc   = '0;
    start_job   = '0;
    start_empty = '0;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      has_body[j]    = (i_tx_packet_body[j*DLEN_WIDTH +: DLEN_WIDTH] != '0) &&
                       (i_tx_body_num[j*BNUM_WIDTH +: BNUM_WIDTH] != '0);
      has_tail[j]    = i_tx_packet_tail[j*DLEN_WIDTH +: DLEN_WIDTH] != '0;
      start_acc[j]   = i_tx_start[j] && !o_ch_busy[j];
      start_job[j]   = start_acc[j] && (has_body[j] || has_tail[j]);
      start_empty[j] = start_acc[j] && !(has_body[j] || has_tail[j]);
    end
  end

  tlk2711_rr_arb #(
    .CH_NUM (CH_NUM)
  ) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_soft_rst),
    .req     (o_ch_busy),
    .adv     (adv),
    .grant_c (grant_c)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned j = 0; j < CH_NUM; j++) begin
      if (grant_c[j]) grant_idx = CH_W'(j);
    end
  end

  // Body commands drain first; body_rem is zero whenever only a tail remains.
  assign nxt_len = (body_rem_q[grant_idx] != '0) ? body_len_q[grant_idx] : tail_len_q[grant_idx];

  always_comb begin
    nxt_data = '0;
    nxt_data[LEN_LSB +: DLEN_WIDTH]      = nxt_len;
    nxt_data[CMD_ADDR_LSB +: ADDR_WIDTH] = addr_q[grant_idx];
  end

  assign cur_len    = o_rd_cmd_data[LEN_LSB +: DLEN_WIDTH];
  assign cur_rem    = body_rem_q[o_rd_cmd_ch];
  assign cur_onehot = CH_NUM'(1) << o_rd_cmd_ch;
  assign fin        = (state == WAIT_LAST) && i_dma_rd_last;
  assign fin_last   = fin && ((cur_rem == '0) ||
                              ((cur_rem == BNUM_WIDTH'(1)) && !tail_pend_q[o_rd_cmd_ch]));
  assign clr_vec    = (fin_last || timeout_hit) ? cur_onehot : '0;
  assign busy_nxt   = (o_ch_busy | start_job) & ~clr_vec;
  assign done_nxt   = start_empty | (fin_last ? cur_onehot : '0);

  always_comb begin
    state_nxt = state;
    req_nxt   = o_rd_cmd_req;
    data_nxt  = o_rd_cmd_data;
    ch_nxt    = o_rd_cmd_ch;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (|busy_nxt) state_nxt = ARB;
      end
      ARB: begin
        if (|grant_c) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          data_nxt  = nxt_data;
          ch_nxt    = grant_idx;
          adv       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (i_rd_cmd_ack) begin
          state_nxt = WAIT_LAST;
          req_nxt   = 1'b0;
        end
      end
      WAIT_LAST: begin
        if (fin || timeout_hit) state_nxt = (|busy_nxt) ? ARB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_soft_rst) begin
      state_nxt = IDLE;
      req_nxt   = 1'b0;
      data_nxt  = '0;
      ch_nxt    = '0;
      adv       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      o_rd_cmd_req  <= 1'b0;
      o_rd_cmd_data <= '0;
      o_rd_cmd_ch   <= '0;
      o_ch_busy     <= '0;
      o_ch_done     <= '0;
    end else begin
      state         <= state_nxt;
      o_rd_cmd_req  <= req_nxt;
      o_rd_cmd_data <= data_nxt;
      o_rd_cmd_ch   <= ch_nxt;
      o_ch_busy     <= i_soft_rst ? '0 : busy_nxt;
      o_ch_done     <= i_soft_rst ? '0 : done_nxt;
    end
  end

  // Per-channel job context: latched on start, advanced on each completed command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < CH_NUM; j++) begin
        addr_q[j]     <= '0;
        body_len_q[j] <= '0;
        tail_len_q[j] <= '0;
        body_rem_q[j] <= '0;
      end
      tail_pend_q <= '0;
    end else if (!i_soft_rst) begin
      for (int unsigned j = 0; j < CH_NUM; j++) begin
        if (start_acc[j]) begin
          addr_q[j]      <= i_tx_base_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          body_len_q[j]  <= i_tx_packet_body[j*DLEN_WIDTH +: DLEN_WIDTH];
          tail_len_q[j]  <= i_tx_packet_tail[j*DLEN_WIDTH +: DLEN_WIDTH];
          body_rem_q[j]  <= has_body[j] ? i_tx_body_num[j*BNUM_WIDTH +: BNUM_WIDTH] : '0;
          tail_pend_q[j] <= has_tail[j];
        end else if (fin && (o_rd_cmd_ch == CH_W'(j))) begin
          addr_q[j] <= addr_q[j] + ADDR_WIDTH'(cur_len);
          if (body_rem_q[j] != '0) begin
            body_rem_q[j] <= body_rem_q[j] - BNUM_WIDTH'(1);
          end else begin
            tail_pend_q[j] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef TLK2711_TX_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th WAIT_LAST cycle unless rd_last arrives then.
  assign timeout_hit = (state == WAIT_LAST) && !i_dma_rd_last &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit && !i_soft_rst;
      if ((state == WAIT_LAST) && (state_nxt == WAIT_LAST)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
